// File: rtl/tank_pkg.sv
// Shared tank-state encoding and sensor-to-state mapping for the pump controller.
package tank_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      HALF  = 2'b01,
      FAULT = 2'b10,
      FULL  = 2'b11
   } tank_state;

   localparam int RUN_W = 8;
   localparam int DEB_W = 4;

   // lo = lower sensor wet, hi = upper sensor wet; upper-only is physically impossible
   function automatic tank_state level_to_state(input logic lo, input logic hi);
      tank_state st;
      case ({lo, hi})
         2'b11:   st = FULL;
         2'b10:   st = HALF;
         2'b00:   st = EMPTY;
         default: st = FAULT;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Level-sensor debounce: output follows raw after DEB consecutive differing samples.
module sensor_debounce
   import tank_pkg::*;
#(
   parameter int DEB = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic filt_o
);

   logic             filt_q, filt_d;
   logic [DEB_W-1:0] cnt_q, cnt_d;

   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (raw_i != filt_q) begin
         if (cnt_q == DEB_W'(DEB - 1)) begin
            filt_d = raw_i;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         filt_q <= 1'b1;
         cnt_q  <= '0;
      end else begin
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign filt_o = filt_q;

endmodule

// File: rtl/multi_pump_ctrl.sv
// Multi-pump sump controller: debounced level sensors pick a tank state, pumps
// follow it with round-robin lead rotation and per-pump minimum run time.
//
//   state | meaning
//   FULL  | both sensors wet, all pumps released
//   HALF  | lower wet only, lead pump runs
//   EMPTY | both dry, every enabled pump runs
//   FAULT | upper wet with lower dry, all pumps forced off
module multi_pump_ctrl
   import tank_pkg::*;
#(
   parameter  int NPUMP   = 4,
   parameter  int MIN_RUN = 8,
   parameter  int DEB     = 2,
   localparam int LW      = (NPUMP > 2) ? $clog2(NPUMP) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             I,
   input  logic             S,
   input  logic [NPUMP-1:0] pump_en,
   output logic [NPUMP-1:0] pump,
   output logic [1:0]       state,
   output logic             fault,
   output logic [LW-1:0]    lead
);

   logic          i_filt, s_filt, any_en;
   tank_state     state_q, state_d, prev_q;
   logic          fault_q, fault_d;
   logic [LW-1:0] lead_q, lead_d;

   sensor_debounce #(.DEB(DEB)) u_deb_i (.clk(clk), .reset(reset), .raw_i(I), .filt_o(i_filt));
   sensor_debounce #(.DEB(DEB)) u_deb_s (.clk(clk), .reset(reset), .raw_i(S), .filt_o(s_filt));

   // Closest enabled index strictly after cur (wrapping); cur itself only as last resort.
   function automatic logic [LW-1:0] next_lead(input logic [LW-1:0] cur,
                                               input logic [NPUMP-1:0] en);
      logic [LW-1:0] r;
      logic [LW-1:0] sel;
      int            idx;
      r = cur;
      for (int i = NPUMP; i >= 1; i--) begin
         idx = (int'(cur) + i) % NPUMP;
         sel = LW'(idx);
         if (en[sel]) r = sel;
      end
      return r;
   endfunction

   always_comb begin
      any_en  = |pump_en;
      state_d = level_to_state(i_filt, s_filt);
      fault_d = (state_d == FAULT) || !any_en;
      lead_d  = lead_q;
      // prev_q lags state_q by one edge, so lead moves on the edge after HALF is entered
      if (any_en && state_q == HALF && (prev_q != HALF || !pump_en[lead_q])) begin
         lead_d = next_lead(lead_q, pump_en);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FULL;
         prev_q  <= FULL;
         fault_q <= 1'b0;
         lead_q  <= LW'(NPUMP - 1);
      end else begin
         state_q <= state_d;
         prev_q  <= state_q;
         fault_q <= fault_d;
         lead_q  <= lead_d;
      end
   end

   for (genvar k = 0; k < NPUMP; k++) begin : g_pump
      logic             on_q, on_d, req, kill;
      logic [RUN_W-1:0] run_q, run_d;

      always_comb begin
         req = 1'b0;
         case (state_q)
            EMPTY:   req = 1'b1;
            HALF:    req = (lead_d == LW'(k));
            default: req = 1'b0;
         endcase
         kill  = (state_q == FAULT) || !pump_en[k];
         on_d  = 1'b0;
         run_d = '0;
         if (!kill) begin
            on_d  = req || (on_q && run_q != '0);
            run_d = run_q;
            if (on_d && !on_q) begin
               run_d = RUN_W'(MIN_RUN - 1);
            end else if (on_q && run_q != '0) begin
               run_d = run_q - 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (!reset) begin
            on_q  <= 1'b0;
            run_q <= '0;
         end else begin
            on_q  <= on_d;
            run_q <= run_d;
         end
      end

      assign pump[k] = on_q;
   end

   assign state = state_q;
   assign fault = fault_q;
   assign lead  = lead_q;

endmodule

// File: tb/tb_multi_pump_ctrl.sv
// Directed bench for multi_pump_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_multi_pump_ctrl;

   localparam int NPUMP   = 4;
   localparam int MIN_RUN = 8;
   localparam int DEB     = 2;

   logic       clk, rst, i_raw, s_raw, fault;
   logic [3:0] pump_en, pump;
   logic [1:0] state, lead;

   int n_tests = 0;
   int n_fail  = 0;

   multi_pump_ctrl #(.NPUMP(NPUMP), .MIN_RUN(MIN_RUN), .DEB(DEB)) dut (
      .clk(clk), .reset(rst), .I(i_raw), .S(s_raw), .pump_en(pump_en),
      .pump(pump), .state(state), .fault(fault), .lead(lead)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       i;
      logic       s;
      logic [3:0] en;
      int         n;
      logic [1:0] st;
      logic [3:0] pmp;
      logic [1:0] ld;
      logic       flt;
   } vec_t;

   vec_t vecs[8];

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input int st, input int pmp, input int ld, input int flt);
      chk({nm, ".state"}, int'(state), st);
      chk({nm, ".pump"},  int'(pump),  pmp);
      chk({nm, ".lead"},  int'(lead),  ld);
      chk({nm, ".fault"}, int'(fault), flt);
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b1, 4'hF, 1,  2'b11, 4'h0, 2'd3, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 4'hF, 2,  2'b11, 4'h0, 2'd3, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 4'hF, 1,  2'b01, 4'h0, 2'd3, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 4'hF, 1,  2'b01, 4'h1, 2'd0, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 4'hF, 3,  2'b11, 4'h1, 2'd0, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 4'hF, 10, 2'b11, 4'h0, 2'd0, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 4'hF, 4,  2'b01, 4'h2, 2'd1, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 4'hF, 12, 2'b11, 4'h0, 2'd1, 1'b0};

      rst = 1'b0; i_raw = 1'b1; s_raw = 1'b1; pump_en = 4'hF;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      for (int v = 0; v < 8; v++) begin
         i_raw   = vecs[v].i;
         s_raw   = vecs[v].s;
         pump_en = vecs[v].en;
         step(vecs[v].n);
         chk_all($sformatf("vec%0d", v), int'(vecs[v].st), int'(vecs[v].pmp),
                 int'(vecs[v].ld), int'(vecs[v].flt));
      end

      // Empty then refill: pumps on after DEB+2 edges, held MIN_RUN on-cycles.
      i_raw = 1'b0; s_raw = 1'b0;
      step(3);
      chk("empty.e3.state", int'(state), 0);
      chk("empty.e3.pump",  int'(pump),  0);
      step(1);
      chk_all("empty.e4", 0, 15, 1, 0);
      step(2);
      i_raw = 1'b1; s_raw = 1'b1;
      for (int e = 7; e <= 14; e++) begin
         step(1);
         chk($sformatf("minrun.e%0d.pump", e),  int'(pump),  (e <= 3 + MIN_RUN) ? 15 : 0);
         chk($sformatf("minrun.e%0d.state", e), int'(state), (e >= 9) ? 3 : 0);
      end

      // Sensor fault cuts pumps despite min-run, then clears.
      i_raw = 1'b0; s_raw = 1'b0;
      step(4);
      chk("pre_fault.pump", int'(pump), 15);
      s_raw = 1'b1;
      step(3);
      chk("fault.state", int'(state), 2);
      chk("fault.fault", int'(fault), 1);
      step(1);
      chk_all("fault.off", 2, 0, 1, 1);
      i_raw = 1'b1;
      step(3);
      chk_all("fault.clear", 3, 0, 1, 0);

      // Single-cycle glitch on S must not change state.
      s_raw = 1'b0;
      step(1);
      s_raw = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         step(1);
         chk($sformatf("glitch.e%0d.state", e), int'(state), 3);
      end

      // Reset mid-run overrides min-run.
      i_raw = 1'b0; s_raw = 1'b0;
      step(4);
      chk("prereset.pump", int'(pump), 15);
      rst = 1'b0;
      step(1);
      chk_all("midreset", 3, 0, 3, 0);
      rst = 1'b1; i_raw = 1'b1; s_raw = 1'b1;
      step(1);
      chk("postreset.pump", int'(pump), 0);

      // Rotation with a partial enable mask, lead drop-out, and all-disabled.
      s_raw = 1'b0;
      step(4);
      chk_all("half.lead0", 1, 1, 0, 0);
      s_raw = 1'b1;
      step(12);
      chk_all("full.idle", 3, 0, 0, 0);
      pump_en = 4'b0101;
      step(1);
      chk_all("mask.idle", 3, 0, 0, 0);
      s_raw = 1'b0;
      step(4);
      chk_all("mask.half", 1, 4, 2, 0);
      pump_en = 4'b0001;
      step(1);
      chk_all("lead_drop", 1, 1, 0, 0);
      pump_en = 4'b0000;
      step(1);
      chk_all("none_en", 1, 0, 0, 1);
      pump_en = 4'b1111;
      step(1);
      chk_all("reenable", 1, 1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_pump_ctrl.md
MULTI_PUMP_CTRL -- requirements
Module: multi_pump_ctrl

Interface
REQ-001 Parameter NPUMP, default 4, number of pumps (legal 2..16).
REQ-002 Parameter MIN_RUN, default 8, minimum on-time per pump in clock cycles (legal 1..255).
REQ-003 Parameter DEB, default 2, sensor debounce length in cycles (legal 1..15).
REQ-004 Derived constant LW = max(1, clog2(NPUMP)), width of the lead index.
REQ-005 clk  input  1  single system clock, all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (reset==0 resets on the rising clk edge).
REQ-007 I  input  1  raw lower level sensor, 1 = water at lower level.
REQ-008 S  input  1  raw upper level sensor, 1 = water at upper level.
REQ-009 pump_en  input  NPUMP  per-pump availability mask, 0 = pump out of service.
REQ-010 pump  output  NPUMP  registered pump drive, 1 = pump on.
REQ-011 state  output  2  registered tank state.
REQ-012 fault  output  1  registered; 1 while state is FAULT or no pump is enabled.
REQ-013 lead  output  LW  registered index of the current lead pump.

Function
REQ-014 Each of I and S shall pass through a debounce filter: the filtered value updates on the DEB-th consecutive rising edge at which raw differs from filtered; a single matching sample clears the count.
REQ-015 State encoding: FULL=2'b11, HALF=2'b01, EMPTY=2'b00, FAULT=2'b10.
REQ-016 Next state from filtered (I,S): (1,1)->FULL, (1,0)->HALF, (0,0)->EMPTY, (0,1)->FAULT, from any state, registered one edge after filter update.
REQ-017 Pump request per state: FULL none, HALF lead pump only, EMPTY all enabled pumps, FAULT none.
REQ-018 On each entry into HALF from a non-HALF state, lead shall advance round-robin to the next index above the current one with pump_en=1, wrapping NPUMP-1 -> 0.
REQ-019 If pump_en is all zero, lead holds, all pumps off, fault=1.
REQ-020 If the lead pump's pump_en drops while in HALF, lead advances immediately (next edge) to the next enabled pump.
REQ-021 Each pump has a run counter loaded with MIN_RUN-1 on its off->on edge, decremented while on, saturating at 0.
REQ-022 A pump whose request drops shall stay on until its run counter is 0, then turn off on the next edge.
REQ-023 Override: FAULT state or pump_en[k]=0 forces pump[k] off on the next edge regardless of run counter, and clears that counter.
REQ-024 pump registers update one edge after state; raw sensor change to pump change latency = DEB+2 edges.
REQ-025 fault is 0 in FULL/HALF/EMPTY whenever any pump_en bit is 1; it is not sticky.

Reset
REQ-026 While reset==0 at a clk edge: pump=0, state=FULL, fault=0, lead=NPUMP-1 (first HALF entry selects pump 0 if enabled), filtered I=S=1, all debounce and run counters 0.
REQ-027 Reset mid-operation shall override min-run hold and turn all pumps off on that edge.

Structure
REQ-028 State encodings and the tank_state type shall reside in shared package tank_pkg.
REQ-029 Debounce shall be sub-module sensor_debounce (parameter DEB), instantiated once for I and once for S.
REQ-030 Run counters and rotation logic shall live in multi_pump_ctrl, generated per pump.

Verification (NPUMP=4, MIN_RUN=8, DEB=2, pump_en=4'b1111)
REQ-031 Reset, then I=S=1 -> state=FULL, pump=0000, lead=3, fault=0.
REQ-032 I=1,S=0 held from edge 0 -> state=HALF at edge 3, pump=0001, lead=0 at edge 4; return to FULL then HALF again -> pump=0010, lead=1.
REQ-033 I=0,S=0 -> pump=1111 at DEB+2 edges; then I=S=1 after 3 cycles -> pumps stay on until 8 on-cycles elapsed, then 0000.
REQ-034 I=0,S=1 while pump=1111 -> state=FAULT, fault=1, pump=0000 next edge despite min-run; return to I=S=1 -> fault=0.
REQ-035 1-cycle glitch on S while FULL -> no state change; pump_en=4'b0101 with lead=0 and re-entry to HALF -> lead=2, pump=0100; pump_en=0 -> fault=1, pump=0000.
